wb_sequencer: RTL and testbench

- Control sequencer for the pipeline's writeback stage.
- Decodes the instruction entering the stage (ir4) and drives the two datapath selects: the z5 source mux select and the store/write-data forwarding select.
- Tracks the stage-5 destination register and produces the register-file write enable and write address.
- Sits beside the writeback datapath and is clocked with the pipeline registers.

---
 rtl/wb_sequencer_if.sv | 34 +++
 rtl/wb_sequencer.sv | 161 ++++++++++++++++
 tb/tb_wb_sequencer.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/wb_sequencer_if.sv
// -----------------------------------------------------------------------------
// wb_sequencer_if
//   Stage-4/stage-5 control bundle between the pipeline control logic
//   (master) and the writeback sequencer (slave).
//
//   ir4_output       instruction currently in stage 4
//   valid4           stage-4 instruction is valid
//   stall            hold stage-5 state this cycle
//   flush            squash the stage-4 instruction (bubble into stage 5)
//   select_z5        z5 source: 0=read_data, 1=z4, 2=pc4
//   select_writedata 0=forward z5_output, 1=md4_output
//   reg_write        register-file write enable (stage 5)
//   write_reg        register-file write address (stage 5)
// -----------------------------------------------------------------------------
interface wb_sequencer_if;
    logic [31:0] ir4_output;
    logic        valid4;
    logic        stall;
    logic        flush;
    logic [1:0]  select_z5;
    logic        select_writedata;
    logic        reg_write;
    logic [4:0]  write_reg;

    modport master (
        output ir4_output, valid4, stall, flush,
        input  select_z5, select_writedata, reg_write, write_reg
    );

    modport slave (
        input  ir4_output, valid4, stall, flush,
        output select_z5, select_writedata, reg_write, write_reg
    );
endinterface

// File: rtl/wb_sequencer.sv
// -----------------------------------------------------------------------------
// wb_sequencer
//   Writeback-stage control sequencer. Decodes the stage-4 instruction to
//   drive the z5 source select and the store write-data forwarding select,
//   and registers the stage-5 destination/write-enable for the register file.
//
//   Ports:
//     clk            pipeline clock
//     rst_n          asynchronous active-low reset
//     bus            wb_sequencer_if.slave (ir4/valid4/stall/flush in,
//                    select_z5/select_writedata/reg_write/write_reg out)
//     illegal_clr    clear the sticky illegal flag (synchronous)
//     illegal_op     sticky: undecodable opcode retired into stage 5
//     retired_count  retired-instruction counter (optional)
//     load_count     retired-load counter (optional)
//
//   Optional feature: define WB_PERF_CNT_EN to build the performance
//   counters; otherwise both counter outputs are tied to zero.
// -----------------------------------------------------------------------------
module wb_sequencer #(
    parameter int unsigned RA_REG = 31,
    parameter int unsigned CNT_W  = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    wb_sequencer_if.slave    bus,
    input  logic             illegal_clr,
    output logic             illegal_op,
    output logic [CNT_W-1:0] retired_count,
    output logic [CNT_W-1:0] load_count
);

    typedef enum logic [5:0] {
        OP_RTYPE = 6'h00,
        OP_J     = 6'h02,
        OP_JAL   = 6'h03,
        OP_BEQ   = 6'h04,
        OP_BNE   = 6'h05,
        OP_ADDI  = 6'h08,
        OP_SLTI  = 6'h0A,
        OP_ANDI  = 6'h0C,
        OP_ORI   = 6'h0D,
        OP_LUI   = 6'h0F,
        OP_LW    = 6'h23,
        OP_SW    = 6'h2B
    } opcode_e;

    localparam logic [4:0] RA_IDX = 5'(RA_REG);

    logic [31:0] ir;
    logic [5:0]  op;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic        unused_ir_bits;

    logic [1:0]  sel_dec;
    logic [4:0]  dest;
    logic        wen_raw;
    logic        wen;
    logic        illegal_dec;
    logic        advance;

    logic        wen5;
    logic [4:0]  dest5;

    assign ir  = bus.ir4_output;
    assign op  = ir[31:26];
    assign rt  = ir[20:16];
    assign rd  = ir[15:11];
    assign unused_ir_bits = ^{ir[25:21], ir[10:0]};

    // Instruction decode; non-writing ops carry dest 0.
    always_comb begin
        sel_dec     = 2'd1;
        dest        = '0;
        wen_raw     = 1'b0;
        illegal_dec = 1'b0;
        case (op)
            OP_RTYPE: begin
                dest    = rd;
                wen_raw = 1'b1;
            end
            OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI, OP_LUI: begin
                dest    = rt;
                wen_raw = 1'b1;
            end
            OP_LW: begin
                sel_dec = 2'd0;
                dest    = rt;
                wen_raw = 1'b1;
            end
            OP_JAL: begin
                sel_dec = 2'd2;
                dest    = RA_IDX;
                wen_raw = 1'b1;
            end
            OP_SW, OP_BEQ, OP_BNE, OP_J: ;
            default: illegal_dec = 1'b1;
        endcase
    end

    // Register 0 is hard-wired; never write it.
    assign wen = wen_raw & (dest != 5'd0);

    assign bus.select_z5 = bus.valid4 ? sel_dec : 2'd1;

    // An instruction moves into stage 5 on this edge.
    assign advance = bus.valid4 & ~bus.stall & ~bus.flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wen5  <= 1'b0;
            dest5 <= '0;
        end else if (!bus.stall) begin
            if (bus.flush || !bus.valid4) begin
                wen5  <= 1'b0;
                dest5 <= '0;
            end else begin
                wen5  <= wen;
                dest5 <= dest;
            end
        end
    end

    assign bus.reg_write = wen5;
    assign bus.write_reg = dest5;

    // A store whose data register is being written by stage 5 takes the
    // forwarded z5 value instead of md4.
    assign bus.select_writedata =
        ~(bus.valid4 & (op == OP_SW) & wen5 & (dest5 == rt));

    // Set has priority over clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            illegal_op <= 1'b0;
        end else if (advance && illegal_dec) begin
            illegal_op <= 1'b1;
        end else if (illegal_clr) begin
            illegal_op <= 1'b0;
        end
    end

`ifdef WB_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retired_count <= '0;
            load_count    <= '0;
        end else if (advance) begin
            retired_count <= retired_count + CNT_W'(1);
            if (op == OP_LW) begin
                load_count <= load_count + CNT_W'(1);
            end
        end
    end
`else
    assign retired_count = '0;
    assign load_count    = '0;
`endif

endmodule

// File: tb/tb_wb_sequencer.sv
// -----------------------------------------------------------------------------
// tb_wb_sequencer
//   Self-checking bench for wb_sequencer: reset behaviour, decode/select
//   vectors, forwarding, bubbles, stall/flush priority, sticky illegal flag,
//   asynchronous mid-operation reset and the optional counters.
// -----------------------------------------------------------------------------
module tb_wb_sequencer;

    localparam int unsigned CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             illegal_clr = 1'b0;
    logic             illegal_op;
    logic [CNT_W-1:0] retired_count;
    logic [CNT_W-1:0] load_count;

    wb_sequencer_if bus ();

    wb_sequencer #(.RA_REG(31), .CNT_W(CNT_W)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .bus           (bus),
        .illegal_clr   (illegal_clr),
        .illegal_op    (illegal_op),
        .retired_count (retired_count),
        .load_count    (load_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] ir;
        logic        v, st, fl, clr;
        logic [1:0]  z5;
        logic        wd;
        logic        rw;
        logic [4:0]  wr;
        logic        wr_chk;
        logic        ill;
    } vec_t;

    typedef struct {
        logic       rw;
        logic [4:0] wr;
        logic       wr_chk;
        logic       ill;
    } exp_t;

    localparam logic [31:0] ADD3  = 32'h0022_1820;
    localparam logic [31:0] ADD4  = 32'h0022_2020;
    localparam logic [31:0] ADD0  = 32'h0022_0020;
    localparam logic [31:0] LW5   = 32'h8C25_0000;
    localparam logic [31:0] JAL   = 32'h0C00_0010;
    localparam logic [31:0] SW3   = 32'hAC23_0004;
    localparam logic [31:0] SW0   = 32'hAC20_0000;
    localparam logic [31:0] ADDI0 = 32'h2000_0005;
    localparam logic [31:0] ADDI2 = 32'h2002_000A;
    localparam logic [31:0] LUI10 = 32'h3C0A_1234;
    localparam logic [31:0] BEQ   = 32'h1022_0003;
    localparam logic [31:0] ILL   = 32'hFC00_0000;

    int n_cmp = 0;
    int n_bad = 0;
    exp_t sb[$];
    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [31:0] ir, input logic v, st, fl, clr,
                                input logic [1:0] z5, input logic wd, rw,
                                input logic [4:0] wr, input logic wr_chk, ill);
        vec_t t;
        t.ir = ir; t.v = v; t.st = st; t.fl = fl; t.clr = clr;
        t.z5 = z5; t.wd = wd; t.rw = rw; t.wr = wr; t.wr_chk = wr_chk; t.ill = ill;
        return t;
    endfunction

    task automatic drive(input logic [31:0] ir, input logic v, st, fl, clr);
        bus.ir4_output = ir;
        bus.valid4     = v;
        bus.stall      = st;
        bus.flush      = fl;
        illegal_clr    = clr;
    endtask

    // Combinational selects are checked before the edge; registered results
    // are queued and compared after the edge.
    task automatic apply(input vec_t t, input int idx);
        exp_t e;
        @(negedge clk);
        drive(t.ir, t.v, t.st, t.fl, t.clr);
        #1;
        check($sformatf("v%0d.select_z5", idx), 32'(bus.select_z5), 32'(t.z5));
        check($sformatf("v%0d.select_writedata", idx), 32'(bus.select_writedata), 32'(t.wd));
        e.rw = t.rw; e.wr = t.wr; e.wr_chk = t.wr_chk; e.ill = t.ill;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            check($sformatf("v%0d.scoreboard_empty", idx), 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            check($sformatf("v%0d.reg_write", idx), 32'(bus.reg_write), 32'(e.rw));
            if (e.wr_chk) check($sformatf("v%0d.write_reg", idx), 32'(bus.write_reg), 32'(e.wr));
            check($sformatf("v%0d.illegal_op", idx), 32'(illegal_op), 32'(e.ill));
        end
    endtask

    task automatic step(input logic [31:0] ir, input logic v, st, fl);
        @(negedge clk);
        drive(ir, v, st, fl, 1'b0);
        @(posedge clk);
    endtask

    initial begin
        //              ir     v  st fl clr z5 wd rw wr chk ill
        vecs.push_back(mk(ADD3,  1, 0, 0, 0, 1, 1, 1, 3,  1, 0));  // 0
        vecs.push_back(mk(LW5,   1, 0, 0, 0, 0, 1, 1, 5,  1, 0));  // 1
        vecs.push_back(mk(JAL,   1, 0, 0, 0, 2, 1, 1, 31, 1, 0));  // 2
        vecs.push_back(mk(ADD3,  1, 0, 0, 0, 1, 1, 1, 3,  1, 0));  // 3
        vecs.push_back(mk(SW3,   1, 0, 0, 0, 1, 0, 0, 0,  0, 0));  // 4 forward
        vecs.push_back(mk(ADD4,  1, 0, 0, 0, 1, 1, 1, 4,  1, 0));  // 5
        vecs.push_back(mk(SW3,   1, 0, 0, 0, 1, 1, 0, 0,  0, 0));  // 6 no fwd
        vecs.push_back(mk(ADDI0, 1, 0, 0, 0, 1, 1, 0, 0,  1, 0));  // 7 $0
        vecs.push_back(mk(ADD3,  1, 0, 1, 0, 1, 1, 0, 0,  1, 0));  // 8 flush
        vecs.push_back(mk(ADD3,  1, 0, 0, 0, 1, 1, 1, 3,  1, 0));  // 9
        vecs.push_back(mk(LW5,   1, 1, 0, 0, 0, 1, 1, 3,  1, 0));  // 10 stall
        vecs.push_back(mk(LW5,   1, 1, 0, 0, 0, 1, 1, 3,  1, 0));  // 11 stall
        vecs.push_back(mk(LW5,   1, 0, 0, 0, 0, 1, 1, 5,  1, 0));  // 12
        vecs.push_back(mk(ADD3,  0, 0, 0, 0, 1, 1, 0, 0,  1, 0));  // 13 invalid
        vecs.push_back(mk(ADD3,  1, 0, 0, 0, 1, 1, 1, 3,  1, 0));  // 14
        vecs.push_back(mk(SW3,   0, 0, 0, 0, 1, 1, 0, 0,  1, 0));  // 15 invalid sw
        vecs.push_back(mk(ADDI2, 1, 0, 0, 0, 1, 1, 1, 2,  1, 0));  // 16
        vecs.push_back(mk(LUI10, 1, 0, 0, 0, 1, 1, 1, 10, 1, 0));  // 17
        vecs.push_back(mk(BEQ,   1, 0, 0, 0, 1, 1, 0, 0,  0, 0));  // 18
        vecs.push_back(mk(ILL,   1, 0, 0, 0, 1, 1, 0, 0,  0, 1));  // 19 set
        vecs.push_back(mk(ADD3,  1, 0, 0, 0, 1, 1, 1, 3,  1, 1));  // 20 sticky
        vecs.push_back(mk(ADD3,  1, 0, 0, 1, 1, 1, 1, 3,  1, 0));  // 21 clear
        vecs.push_back(mk(ILL,   1, 1, 0, 0, 1, 1, 1, 3,  1, 0));  // 22 stalled ill
        vecs.push_back(mk(ILL,   1, 0, 1, 0, 1, 1, 0, 0,  1, 0));  // 23 flushed ill
        vecs.push_back(mk(ILL,   1, 0, 0, 1, 1, 1, 0, 0,  0, 1));  // 24 set beats clr
        vecs.push_back(mk(ADD3,  1, 0, 0, 1, 1, 1, 1, 3,  1, 0));  // 25
        vecs.push_back(mk(ADD0,  1, 0, 0, 0, 1, 1, 0, 0,  1, 0));  // 26 rd=0
        vecs.push_back(mk(SW0,   1, 0, 0, 0, 1, 1, 0, 0,  0, 0));  // 27 sw $0
        vecs.push_back(mk(ADD4,  1, 0, 0, 0, 1, 1, 1, 4,  1, 0));  // 28
        vecs.push_back(mk(ADD3,  1, 1, 1, 0, 1, 1, 1, 4,  1, 0));  // 29 stalled flush
        vecs.push_back(mk(ADD3,  1, 0, 1, 0, 1, 1, 0, 0,  1, 0));  // 30 flush lands

        // Reset asserted with a valid add in stage 4.
        drive(ADD3, 1'b1, 1'b0, 1'b0, 1'b0);
        #2;
        check("rst.reg_write", 32'(bus.reg_write), 32'd0);
        check("rst.write_reg", 32'(bus.write_reg), 32'd0);
        check("rst.select_writedata", 32'(bus.select_writedata), 32'd1);
        check("rst.illegal_op", 32'(illegal_op), 32'd0);
        check("rst.select_z5", 32'(bus.select_z5), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rel.reg_write", 32'(bus.reg_write), 32'd1);
        check("rel.write_reg", 32'(bus.write_reg), 32'd3);
        check("rel.select_z5", 32'(bus.select_z5), 32'd1);

        foreach (vecs[i]) apply(vecs[i], i);

        // Asynchronous reset in the middle of a cycle with a forwarding store.
        @(negedge clk);
        drive(ADD3, 1'b1, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        @(negedge clk);
        drive(SW3, 1'b1, 1'b0, 1'b0, 1'b0);
        #1;
        check("arst.pre_select_writedata", 32'(bus.select_writedata), 32'd0);
        rst_n = 1'b0;
        #1;
        check("arst.reg_write", 32'(bus.reg_write), 32'd0);
        check("arst.write_reg", 32'(bus.write_reg), 32'd0);
        check("arst.select_writedata", 32'(bus.select_writedata), 32'd1);
        check("arst.retired_count", 32'(retired_count), 32'd0);
        check("arst.load_count", 32'(load_count), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Counters: 4 retired (2 loads), one stalled and one flushed cycle.
        step(LW5,  1'b1, 1'b0, 1'b0);
        step(ADD3, 1'b1, 1'b0, 1'b0);
        step(LW5,  1'b1, 1'b0, 1'b0);
        step(LW5,  1'b1, 1'b1, 1'b0);
        step(LW5,  1'b1, 1'b0, 1'b1);
        step(ADD3, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        drive(ADD3, 1'b0, 1'b0, 1'b0, 1'b0);
`ifdef WB_PERF_CNT_EN
        check("cnt.retired", 32'(retired_count), 32'd4);
        check("cnt.loads", 32'(load_count), 32'd2);
`else
        check("cnt.retired", 32'(retired_count), 32'd0);
        check("cnt.loads", 32'(load_count), 32'd0);
`endif
        // Twelve more retirements take a 4-bit counter from 4 through 15 to 0.
        for (int i = 0; i < 12; i++) step(ADD3, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        drive(ADD3, 1'b0, 1'b0, 1'b0, 1'b0);
`ifdef WB_PERF_CNT_EN
        check("cnt.wrap_retired", 32'(retired_count), 32'd0);
        check("cnt.wrap_loads", 32'(load_count), 32'd2);
`else
        check("cnt.wrap_retired", 32'(retired_count), 32'd0);
        check("cnt.wrap_loads", 32'(load_count), 32'd0);
`endif

        if (sb.size() != 0) check("scoreboard.leftover", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
